sha256_id_issuer: RTL

//  Generates the per-job ID stream that feeds the config synchroniser's id_in port.

---
 rtl/sha256_id_issuer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sha256_id_issuer.sv
// sha256_id_issuer: issues single-beat job IDs, retires them in order, caps jobs in flight.
// Latency: id_out_valid registered 1 cycle after en is sampled with a free slot; at least 2 cycles per ID.
// Backpressure: offer held until id_out_ready; no offers while full. Optional watchdog: SHA256_ID_ISSUER_TIMEOUT_EN.
module sha256_id_issuer #(
  parameter int ID_W            = 6,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   en,
  input  logic                                   sync_rst,
  output logic [ID_W-1:0]                        id_out,
  output logic                                   id_out_last,
  output logic                                   id_out_valid,
  input  logic                                   id_out_ready,
  input  logic [ID_W-1:0]                        done_in_id,
  input  logic                                   done_in_valid,
  output logic                                   done_in_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   busy,
  output logic                                   err_order,
  output logic                                   timeout
);

  localparam int OCW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [OCW-1:0] MAX_CNT = OCW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, OFFER, FULL} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] oldest_id;
  logic [OCW-1:0]  cnt_nxt;
  logic            id_hs, done_hs, slot_free;

  assign id_hs       = id_out_valid & id_out_ready;
  assign done_hs     = done_in_valid & done_in_ready;
  // A completion in the same cycle frees a slot, so FULL is not entered then.
  assign slot_free   = (outstanding < MAX_CNT) | done_hs;
  assign id_out_last = id_out_valid;

  always_comb begin
    cnt_nxt   = outstanding;
    state_nxt = state;
    if (id_hs && !done_hs)
      cnt_nxt = outstanding + OCW'(1);
    else if (done_hs && !id_hs)
      cnt_nxt = outstanding - OCW'(1);
    case (state)
      IDLE: begin
        if (!slot_free)
          state_nxt = FULL;
        else if (en)
          state_nxt = OFFER;
      end
      OFFER: if (id_hs) state_nxt = IDLE;
      FULL:  if (done_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      id_out        <= '0;
      id_out_valid  <= 1'b0;
      oldest_id     <= '0;
      outstanding   <= '0;
      done_in_ready <= 1'b0;
      busy          <= 1'b0;
      err_order     <= 1'b0;
    end else if (sync_rst) begin
      state         <= IDLE;
      id_out        <= '0;
      id_out_valid  <= 1'b0;
      oldest_id     <= '0;
      outstanding   <= '0;
      done_in_ready <= 1'b0;
      busy          <= 1'b0;
      err_order     <= 1'b0;
    end else begin
      state         <= state_nxt;
      id_out_valid  <= (state_nxt == OFFER);
      outstanding   <= cnt_nxt;
      done_in_ready <= (cnt_nxt != '0);
      busy          <= (cnt_nxt != '0) || (state_nxt == OFFER);
      // id_out doubles as the next-ID counter; it is only advanced by a handshake.
      if (id_hs)
        id_out <= id_out + ID_W'(1);
      if (done_hs)
        oldest_id <= oldest_id + ID_W'(1);
      if (done_hs && (done_in_id != oldest_id))
        err_order <= 1'b1;
    end
  end

`ifdef SHA256_ID_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  assign tmo_run = (outstanding != '0) && !done_hs;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (sync_rst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (!tmo_run)
        tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
        tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_run && (tmo_cnt == TW'(TIMEOUT_CYCLES-1)))
        timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
